mem_copy_engine: RTL and testbench



---
 rtl/mem_copy_engine_if.sv | 38 +++
 rtl/mem_copy_engine.sv | 108 ++++++++++
 tb/tb_mem_copy_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Command handshake and 2R/2W RAM port bundle for mem_copy_engine.
// slave = the copy engine, master = the command source plus RAM.
interface mem_copy_engine_if #(
  parameter int P_MEM_DEPTH = 2048,
  parameter int P_MEM_WIDTH = 32
);
  localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);

  logic [LP_INDEX_WIDTH-1:0] cmd_src_i;
  logic [LP_INDEX_WIDTH-1:0] cmd_dst_i;
  logic [LP_INDEX_WIDTH:0]   cmd_len_i;
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic                      busy_o;
  logic                      done_o;
  logic [LP_INDEX_WIDTH-1:0] rda_addr_o;
  logic [LP_INDEX_WIDTH-1:0] rdb_addr_o;
  logic [P_MEM_WIDTH-1:0]    rda_data_i;
  logic [P_MEM_WIDTH-1:0]    rdb_data_i;
  logic [LP_INDEX_WIDTH-1:0] wra_addr_o;
  logic [LP_INDEX_WIDTH-1:0] wrb_addr_o;
  logic [P_MEM_WIDTH-1:0]    wra_data_o;
  logic [P_MEM_WIDTH-1:0]    wrb_data_o;
  logic                      wra_valid_o;
  logic                      wrb_valid_o;

  modport slave (
    input  cmd_src_i, cmd_dst_i, cmd_len_i, cmd_valid_i, rda_data_i, rdb_data_i,
    output cmd_ready_o, busy_o, done_o, rda_addr_o, rdb_addr_o,
           wra_addr_o, wrb_addr_o, wra_data_o, wrb_data_o, wra_valid_o, wrb_valid_o
  );

  modport master (
    output cmd_src_i, cmd_dst_i, cmd_len_i, cmd_valid_i, rda_data_i, rdb_data_i,
    input  cmd_ready_o, busy_o, done_o, rda_addr_o, rdb_addr_o,
           wra_addr_o, wrb_addr_o, wra_data_o, wrb_data_o, wra_valid_o, wrb_valid_o
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: two words per clock over the multiport RAM, port A even
// offsets, port B odd offsets; writes trail reads by one beat.
module mem_copy_engine #(
  parameter int P_MEM_DEPTH = 2048,
  parameter int P_MEM_WIDTH = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_copy_engine_if.slave bus
);
  localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);

  typedef logic [LP_INDEX_WIDTH-1:0] idx_t;
  typedef logic [LP_INDEX_WIDTH:0]   len_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    idx_t dst;
    idx_t nbeats;
    logic odd;
  } cmd_t;

  state_t state_q, state_d;
  cmd_t   cmd_q;
  idx_t   beat_q;
  idx_t   rda_addr_q, rdb_addr_q, wra_addr_q, wrb_addr_q;
  logic   wra_vld_q, wrb_vld_q, done_q;

  logic   cmd_ready, accept, last_beat, len_zero;
  len_t   len_clamp, beats_full;
  idx_t   wr_base;

  // Lengths above the RAM depth are clamped to a full-memory copy.
  assign len_clamp  = (bus.cmd_len_i > len_t'(P_MEM_DEPTH)) ? len_t'(P_MEM_DEPTH) : bus.cmd_len_i;
  assign beats_full = (len_clamp + len_t'(1)) >> 1;
  assign len_zero   = (len_clamp == '0);
  assign wr_base    = cmd_q.dst + {beat_q[LP_INDEX_WIDTH-2:0], 1'b0};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = (state_q == S_IDLE);
    accept    = cmd_ready && bus.cmd_valid_i;
    last_beat = (beat_q == cmd_q.nbeats - idx_t'(1));
    case (state_q)
      S_IDLE:  if (accept && !len_zero) state_d = S_RUN;
      S_RUN:   if (last_beat)           state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q      <= '0;
      beat_q     <= '0;
      rda_addr_q <= '0;
      rdb_addr_q <= '0;
      wra_addr_q <= '0;
      wrb_addr_q <= '0;
      wra_vld_q  <= 1'b0;
      wrb_vld_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == S_DRAIN) || (accept && len_zero);

      if (accept && !len_zero) begin
        cmd_q.dst    <= bus.cmd_dst_i;
        cmd_q.nbeats <= beats_full[LP_INDEX_WIDTH-1:0];
        cmd_q.odd    <= len_clamp[0];
        beat_q       <= '0;
        rda_addr_q   <= bus.cmd_src_i;
        rdb_addr_q   <= bus.cmd_src_i + idx_t'(1);
      end else if (state_q == S_RUN && !last_beat) begin
        beat_q     <= beat_q + idx_t'(1);
        rda_addr_q <= rda_addr_q + idx_t'(2);
        rdb_addr_q <= rdb_addr_q + idx_t'(2);
      end

      // Write side replays the beat just read; RAM data returns next cycle.
      if (state_q == S_RUN) begin
        wra_addr_q <= wr_base;
        wrb_addr_q <= wr_base + idx_t'(1);
        wra_vld_q  <= 1'b1;
        wrb_vld_q  <= !(last_beat && cmd_q.odd);
      end else begin
        wra_vld_q  <= 1'b0;
        wrb_vld_q  <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.busy_o      = !cmd_ready;
  assign bus.done_o      = done_q;
  assign bus.rda_addr_o  = rda_addr_q;
  assign bus.rdb_addr_o  = rdb_addr_q;
  assign bus.wra_addr_o  = wra_addr_q;
  assign bus.wrb_addr_o  = wrb_addr_q;
  assign bus.wra_valid_o = wra_vld_q;
  assign bus.wrb_valid_o = wrb_vld_q;
  assign bus.wra_data_o  = bus.rda_data_i;
  assign bus.wrb_data_o  = bus.rdb_data_i;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: RAM model plus a copy-semantics reference memory,
// directed cases followed by random commands.
module tb_mem_copy_engine;
  localparam int D  = 2048;
  localparam int W  = 32;
  localparam int AW = 11;

  typedef struct {int src; int dst; int len;} cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_copy_engine_if #(.P_MEM_DEPTH(D), .P_MEM_WIDTH(W)) bus ();
  mem_copy_engine #(.P_MEM_DEPTH(D), .P_MEM_WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  logic [W-1:0] mem     [D];
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] old_mem [D];
  logic          init_en = 1'b1;
  logic          pk_en   = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [W-1:0]  pk_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] seed_val(int i);
    return (W'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [AW-1:0] idx(int a);
    return AW'(a & (D - 1));
  endfunction

  // Registered-read RAM with read-before-write on the same address.
  always @(posedge clk) begin
    bus.rda_data_i <= mem[bus.rda_addr_o];
    bus.rdb_data_i <= mem[bus.rdb_addr_o];
    if (init_en) for (int i = 0; i < D; i++) mem[i] <= seed_val(i);
    if (pk_en) mem[pk_addr] <= pk_data;
    if (bus.wra_valid_o) mem[bus.wra_addr_o] <= bus.wra_data_o;
    if (bus.wrb_valid_o) mem[bus.wrb_addr_o] <= bus.wrb_data_o;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_cmp(input string tag);
    int nmis;
    nmis = 0;
    for (int i = 0; i < D; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk(tag, 64'(nmis), 64'd0);
  endtask

  task automatic poke(input int a, input logic [W-1:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = idx(a); pk_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic drive(input cmd_t c);
    bus.cmd_src_i   = idx(c.src);
    bus.cmd_dst_i   = idx(c.dst);
    bus.cmd_len_i   = (AW+1)'(c.len);
    bus.cmd_valid_i = 1'b1;
  endtask

  task automatic issue(input cmd_t c);
    @(negedge clk);
    chk("ready_before_cmd", 64'(bus.cmd_ready_o), 64'd1);
    drive(c);
    @(posedge clk);
  endtask

  // Checks cycles 1..done of a command accepted at the preceding posedge,
  // then applies snapshot copy semantics to the reference memory.
  task automatic watch(input cmd_t c, input bit hold, input cmd_t nxt);
    int L, N, ed, errs, k;
    bit busy_e, va, vb;
    L = (c.len > D) ? D : c.len;
    N = (L + 1) / 2;
    ed = (L == 0) ? 1 : N + 2;
    errs = 0;
    for (int i = 0; i < D; i++) old_mem[i] = ref_mem[i];
    for (int cy = 1; cy <= ed; cy++) begin
      @(negedge clk);
      busy_e = (L > 0) && (cy <= N + 1);
      va     = (L > 0) && (cy >= 2) && (cy <= N + 1);
      vb     = va && !(cy == N + 1 && (L % 2) == 1);
      k      = cy - 2;
      if (bus.busy_o !== busy_e)       errs++;
      if (bus.cmd_ready_o !== !busy_e) errs++;
      if (bus.done_o !== (cy == ed))   errs++;
      if (L > 0 && cy <= N) begin
        if (bus.rda_addr_o !== idx(c.src + 2*(cy-1)))     errs++;
        if (bus.rdb_addr_o !== idx(c.src + 2*(cy-1) + 1)) errs++;
      end
      if (bus.wra_valid_o !== va) errs++;
      if (bus.wrb_valid_o !== vb) errs++;
      if (va) begin
        if (bus.wra_addr_o !== idx(c.dst + 2*k))          errs++;
        if (bus.wra_data_o !== old_mem[idx(c.src + 2*k)]) errs++;
      end
      if (vb) begin
        if (bus.wrb_addr_o !== idx(c.dst + 2*k + 1))          errs++;
        if (bus.wrb_data_o !== old_mem[idx(c.src + 2*k + 1)]) errs++;
      end
      if (cy == 1) begin
        if (hold) drive(nxt);
        else bus.cmd_valid_i = 1'b0;
      end
    end
    chk($sformatf("seq src=%0d dst=%0d len=%0d errs", c.src, c.dst, c.len), 64'(errs), 64'd0);
    for (int i = 0; i < L; i++) ref_mem[idx(c.dst + i)] = old_mem[idx(c.src + i)];
    mem_cmp($sformatf("mem src=%0d dst=%0d len=%0d bad_words", c.src, c.dst, c.len));
  endtask

  initial begin
    cmd_t c, c2, none;
    logic [W-1:0] w0, w1, w2;
    int L, d, dones;
    none = '{0, 0, 0};
    bus.cmd_valid_i = 1'b0;
    bus.cmd_src_i = '0; bus.cmd_dst_i = '0; bus.cmd_len_i = '0;
    for (int i = 0; i < D; i++) ref_mem[i] = seed_val(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.cmd_ready_o), 64'd1);
    chk("rst_busy",  64'(bus.busy_o),      64'd0);
    chk("rst_done",  64'(bus.done_o),      64'd0);
    chk("rst_wra_v", 64'(bus.wra_valid_o), 64'd0);
    chk("rst_wrb_v", 64'(bus.wrb_valid_o), 64'd0);
    chk("rst_rda",   64'(bus.rda_addr_o),  64'd0);
    rst = 1'b0; init_en = 1'b0;

    // even copy
    for (int i = 0; i < 4; i++) poke(16'h010 + i, W'(8'hA0 + i));
    c = '{16'h010, 16'h100, 4}; issue(c); watch(c, 1'b0, none);
    chk("even_m100", 64'(mem[16'h100]), 64'hA0);
    chk("even_m103", 64'(mem[16'h103]), 64'hA3);

    // odd copy leaves the word after the block alone
    poke(16'h103, 32'hEE);
    c = '{16'h010, 16'h100, 3}; issue(c); watch(c, 1'b0, none);
    chk("odd_m103", 64'(mem[16'h103]), 64'hEE);

    // wrap-around
    w0 = ref_mem[2046]; w1 = ref_mem[2047]; w2 = ref_mem[0];
    c = '{2046, 2047, 3}; issue(c); watch(c, 1'b0, none);
    chk("wrap_m2047", 64'(mem[2047]), 64'(w0));
    chk("wrap_m0",    64'(mem[0]),    64'(w1));
    chk("wrap_m1",    64'(mem[1]),    64'(w2));

    // edge lengths
    c = '{16'h020, 16'h200, 0};    issue(c); watch(c, 1'b0, none);
    c = '{16'h000, 16'h000, 4000}; issue(c); watch(c, 1'b0, none);

    // back-to-back with cmd_valid held high
    c  = '{16'h020, 16'h300, 5};
    c2 = '{16'h040, 16'h380, 6};
    issue(c); watch(c, 1'b1, c2);
    @(posedge clk);
    watch(c2, 1'b0, none);

    // abort in cycle 2 of a len 8 copy
    c = '{16'h050, 16'h400, 8};
    issue(c);
    @(negedge clk); bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("abort_c2_wra_v", 64'(bus.wra_valid_o), 64'd1);
    chk("abort_c2_wrb_v", 64'(bus.wrb_valid_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  64'(bus.busy_o),      64'd0);
    chk("abort_ready", 64'(bus.cmd_ready_o), 64'd1);
    chk("abort_wra_v", 64'(bus.wra_valid_o), 64'd0);
    chk("abort_wrb_v", 64'(bus.wrb_valid_o), 64'd0);
    chk("abort_rda",   64'(bus.rda_addr_o),  64'd0);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    ref_mem[16'h400] = ref_mem[16'h050];
    ref_mem[16'h401] = ref_mem[16'h051];
    mem_cmp("abort_mem bad_words");

    // random commands, overlapping-forward cases folded onto dst == src
    repeat (30) begin
      c.src = int'($urandom_range(0, D-1));
      c.dst = int'($urandom_range(0, D-1));
      c.len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2200)) : int'($urandom_range(0, 40));
      L = (c.len > D) ? D : c.len;
      d = int'(idx(c.dst - c.src + D));
      if (d > 0 && d < L) c.dst = c.src;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(c);
      watch(c, 1'b0, none);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
